// File: rtl/prng_pkg.sv
// Shared types and default constants for the PRNG generator.
package prng_pkg;

  typedef enum logic {
    GEN  = 1'b0,
    HOLD = 1'b1
  } prng_state_e;

  localparam logic [31:0] DEFAULT_TAPS      = 32'h6000_0201;
  localparam logic [63:0] DEFAULT_INIT_SEED = {64{1'b1}};

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR shift: right shift, XOR of tapped bits enters the MSB.
module lfsr_step
  import prng_pkg::*;
#(
  parameter int                 WIDTH = 32,
  parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(DEFAULT_TAPS)
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  assign state_o = {^(state_i & TAPS), state_i[WIDTH-1:1]};

endmodule

// File: rtl/prng_gen.sv
// LFSR word generator: STEPS shifts per word, valid/ready output hold,
// runtime reseed with zero-seed rejection, and an accepted-word counter.
module prng_gen
  import prng_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] INIT_SEED = DEFAULT_INIT_SEED[WIDTH-1:0],
  parameter int               STEPS     = 1
) (
  input  logic             CLK,
  input  logic             RESETL,
  input  logic             ENABLE,
  input  logic             SEED_VLD,
  input  logic [WIDTH-1:0] SEED,
  input  logic             OUT_READY,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUTDATA,
  output logic             SEED_ERR,
  output logic [31:0]      WORD_CNT
);

  localparam int             CW      = $clog2(STEPS + 1);
  localparam logic [CW-1:0]  STEPS_C = CW'(STEPS);
  localparam logic [CW-1:0]  ONE_C   = CW'(1);

  prng_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d, shifted;
  logic [CW-1:0]    step_q, step_d;
  logic             seed_err_q, seed_err_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic             accept;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_step (
    .state_i (state_q),
    .state_o (shifted)
  );

  always_ff @(posedge CLK) begin
    if (!RESETL) begin
      fsm_q      <= GEN;
      state_q    <= INIT_SEED;
      step_q     <= STEPS_C;
      seed_err_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      step_q     <= step_d;
      seed_err_q <= seed_err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    step_d     = step_q;
    seed_err_d = 1'b0;
    word_cnt_d = word_cnt_q;
    accept     = (fsm_q == HOLD) && OUT_READY;

    // A word offered in HOLD counts as taken even if a reseed wins the state load.
    if (accept) word_cnt_d = word_cnt_q + 32'd1;

    if (SEED_VLD) begin
      fsm_d  = GEN;
      step_d = STEPS_C;
      if (SEED == '0) begin
        state_d    = INIT_SEED;
        seed_err_d = 1'b1;
      end else begin
        state_d = SEED;
      end
    end else begin
      case (fsm_q)
        GEN: begin
          if (ENABLE) begin
            state_d = shifted;
            if (step_q == ONE_C) fsm_d = HOLD;
            else                 step_d = step_q - ONE_C;
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            fsm_d  = GEN;
            step_d = STEPS_C;
          end
        end
        default: fsm_d = GEN;
      endcase
    end
  end

  assign OUT_VALID = (fsm_q == HOLD);
  assign OUTDATA   = state_q;
  assign SEED_ERR  = seed_err_q;
  assign WORD_CNT  = word_cnt_q;

endmodule

// File: tb/tb_prng_gen.sv
// Directed bench for prng_gen: four configurations (default, STEPS=4,
// STEPS=3, 8-bit maximal-length) exercised one scenario task at a time.
module tb_prng_gen;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Instance A: defaults
  logic a_rst, a_en, a_sv, a_rdy, a_vld, a_err;
  logic [31:0] a_seed, a_data, a_wc;
  // Instance B: STEPS=4
  logic b_rst, b_en, b_sv, b_rdy, b_vld, b_err;
  logic [31:0] b_seed, b_data, b_wc;
  // Instance C: STEPS=3
  logic c_rst, c_en, c_sv, c_rdy, c_vld, c_err;
  logic [31:0] c_seed, c_data, c_wc;
  // Instance D: 8-bit
  logic d_rst, d_en, d_sv, d_rdy, d_vld, d_err;
  logic [7:0]  d_seed, d_data;
  logic [31:0] d_wc;

  prng_gen u_a (
    .CLK(CLK), .RESETL(a_rst), .ENABLE(a_en), .SEED_VLD(a_sv), .SEED(a_seed),
    .OUT_READY(a_rdy), .OUT_VALID(a_vld), .OUTDATA(a_data), .SEED_ERR(a_err), .WORD_CNT(a_wc)
  );

  prng_gen #(.STEPS(4)) u_b (
    .CLK(CLK), .RESETL(b_rst), .ENABLE(b_en), .SEED_VLD(b_sv), .SEED(b_seed),
    .OUT_READY(b_rdy), .OUT_VALID(b_vld), .OUTDATA(b_data), .SEED_ERR(b_err), .WORD_CNT(b_wc)
  );

  prng_gen #(.STEPS(3)) u_c (
    .CLK(CLK), .RESETL(c_rst), .ENABLE(c_en), .SEED_VLD(c_sv), .SEED(c_seed),
    .OUT_READY(c_rdy), .OUT_VALID(c_vld), .OUTDATA(c_data), .SEED_ERR(c_err), .WORD_CNT(c_wc)
  );

  // 8'h1D is the bit-reversed form of the classic 8'hB8 polynomial
  // (x^8+x^4+x^3+x^2+1), which is what a right-shift Fibonacci needs.
  prng_gen #(.WIDTH(8), .TAPS(8'h1D), .INIT_SEED(8'hFF), .STEPS(1)) u_d (
    .CLK(CLK), .RESETL(d_rst), .ENABLE(d_en), .SEED_VLD(d_sv), .SEED(d_seed),
    .OUT_READY(d_rdy), .OUT_VALID(d_vld), .OUTDATA(d_data), .SEED_ERR(d_err), .WORD_CNT(d_wc)
  );

  function automatic logic [31:0] nxt32(input logic [31:0] x);
    return {^(x & 32'h6000_0201), x[31:1]};
  endfunction

  function automatic logic [7:0] nxt8(input logic [7:0] x);
    return {^(x & 8'h1D), x[7:1]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b0; a_en = 1'b1; a_sv = 1'b1; a_seed = 32'h5; a_rdy = 1'b1;
    tick();
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_vld); end
    checks++; if (a_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_data got %h want ffffffff", a_data); end
    checks++; if (a_wc !== 32'd0) begin errors++; $display("FAIL reset_wc got %0d want 0", a_wc); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", a_err); end
    a_sv = 1'b0; a_seed = '0;
  endtask

  task automatic test_default_seq();
    a_rst = 1'b1; a_en = 1'b1; a_rdy = 1'b1;
    tick();
    checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", a_vld); end
    checks++; if (a_data !== 32'h7FFF_FFFF) begin errors++; $display("FAIL first_word got %h want 7fffffff", a_data); end
    tick();
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL post_hs_valid got %b want 0", a_vld); end
    checks++; if (a_wc !== 32'd1) begin errors++; $display("FAIL post_hs_wc got %0d want 1", a_wc); end
    a_rdy = 1'b0;
    tick();
    checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL second_valid got %b want 1", a_vld); end
    checks++; if (a_data !== 32'h3FFF_FFFF) begin errors++; $display("FAIL second_word got %h want 3fffffff", a_data); end
  endtask

  task automatic test_zero_seed_hold();
    a_sv = 1'b1; a_seed = 32'h0;
    tick();
    a_sv = 1'b0;
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL zseed_err got %b want 1", a_err); end
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL zseed_valid got %b want 0", a_vld); end
    checks++; if (a_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zseed_data got %h want ffffffff", a_data); end
    tick();
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL zseed_pulse got %b want 0", a_err); end
    checks++; if (a_data !== 32'h7FFF_FFFF || a_vld !== 1'b1) begin
      errors++; $display("FAIL zseed_next got %h/%b want 7fffffff/1", a_data, a_vld); end
    checks++; if (a_wc !== 32'd1) begin errors++; $display("FAIL zseed_wc got %0d want 1", a_wc); end
  endtask

  task automatic test_seed_handshake();
    a_rdy = 1'b1; a_sv = 1'b1; a_seed = 32'h1234_5678;
    tick();
    a_sv = 1'b0; a_rdy = 1'b0;
    checks++; if (a_wc !== 32'd2) begin errors++; $display("FAIL seedhs_wc got %0d want 2", a_wc); end
    checks++; if (a_data !== 32'h1234_5678 || a_vld !== 1'b0) begin
      errors++; $display("FAIL seedhs_load got %h/%b want 12345678/0", a_data, a_vld); end
    tick();
    checks++; if (a_data !== 32'h891A_2B3C || a_vld !== 1'b1) begin
      errors++; $display("FAIL seedhs_word got %h/%b want 891a2b3c/1", a_data, a_vld); end
  endtask

  task automatic test_reset_mid_hold();
    a_rst = 1'b0; a_sv = 1'b1; a_seed = 32'h5; a_rdy = 1'b1;
    tick();
    checks++; if (a_data !== 32'hFFFF_FFFF || a_vld !== 1'b0 || a_wc !== 32'd0) begin
      errors++; $display("FAIL rst_hold got %h/%b/%0d want ffffffff/0/0", a_data, a_vld, a_wc); end
    a_rst = 1'b1; a_sv = 1'b0; a_rdy = 1'b0;
  endtask

  task automatic test_seed_over_enable();
    a_en = 1'b0; a_sv = 1'b1; a_seed = 32'hA5A5_A5A5;
    tick();
    a_sv = 1'b0;
    checks++; if (a_data !== 32'hA5A5_A5A5 || a_vld !== 1'b0) begin
      errors++; $display("FAIL seed_noen got %h/%b want a5a5a5a5/0", a_data, a_vld); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (a_data !== 32'hA5A5_A5A5 || a_vld !== 1'b0) begin
      errors++; $display("FAIL en0_freeze got %h/%b want a5a5a5a5/0", a_data, a_vld); end
    a_en = 1'b1;
    tick();
    checks++; if (a_data !== nxt32(32'hA5A5_A5A5) || a_vld !== 1'b1) begin
      errors++; $display("FAIL en1_resume got %h/%b want %h/1", a_data, a_vld, nxt32(32'hA5A5_A5A5)); end
  endtask

  task automatic test_steps4_hold();
    logic [31:0] exp_w;
    logic [31:0] held;
    int bad;
    exp_w = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) exp_w = nxt32(exp_w);
    b_rst = 1'b1; b_en = 1'b1; b_rdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (b_vld !== 1'b0) begin errors++; $display("FAIL s4_early c%0d got %b want 0", i, b_vld); end
    end
    tick();
    checks++; if (b_vld !== 1'b1 || b_data !== exp_w) begin
      errors++; $display("FAIL s4_word got %h/%b want %h/1", b_data, b_vld, exp_w); end
    held = b_data; bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_data !== held || b_vld !== 1'b1) bad++;
    end
    checks++; if (bad != 0 || b_data !== exp_w) begin
      errors++; $display("FAIL s4_hold got %0d unstable cycles, data %h want %h", bad, b_data, exp_w); end
  endtask

  task automatic test_enable_toggle();
    logic [31:0] exp_w;
    exp_w = nxt32(nxt32(nxt32(32'hFFFF_FFFF)));
    c_rst = 1'b1; c_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_en = (i % 2 == 0);
      tick();
      checks++; if (c_vld !== 1'b0) begin errors++; $display("FAIL tog_early c%0d got %b want 0", i, c_vld); end
    end
    c_en = 1'b1;
    tick();
    checks++; if (c_vld !== 1'b1 || c_data !== exp_w) begin
      errors++; $display("FAIL tog_word got %h/%b want %h/1", c_data, c_vld, exp_w); end
    c_en = 1'b0; c_rdy = 1'b1;
    tick();
    checks++; if (c_vld !== 1'b0 || c_wc !== 32'd1) begin
      errors++; $display("FAIL tog_hs_en0 got %b/%0d want 0/1", c_vld, c_wc); end
  endtask

  task automatic test_width8_period();
    logic [255:0] seen;
    logic [7:0]   e, last;
    int n, cyc, bad_model, bad_zero, bad_rep;
    seen = '0; e = 8'hFF; last = 8'h00;
    n = 0; cyc = 0; bad_model = 0; bad_zero = 0; bad_rep = 0;
    d_rst = 1'b1; d_en = 1'b1; d_rdy = 1'b1;
    while (n < 255 && cyc < 2000) begin
      tick(); cyc++;
      if (d_vld === 1'b1) begin
        e = nxt8(e);
        if (d_data !== e) bad_model++;
        if (d_data === 8'h00) bad_zero++;
        if (seen[d_data]) bad_rep++;
        seen[d_data] = 1'b1;
        last = d_data;
        n++;
      end
    end
    checks++; if (n != 255) begin errors++; $display("FAIL w8_count got %0d words want 255", n); end
    checks++; if (bad_model != 0) begin errors++; $display("FAIL w8_model got %0d bad words want 0", bad_model); end
    checks++; if (bad_zero != 0) begin errors++; $display("FAIL w8_zero got %0d zero words want 0", bad_zero); end
    checks++; if (bad_rep != 0) begin errors++; $display("FAIL w8_repeat got %0d repeats want 0", bad_rep); end
    checks++; if (last !== 8'hFF) begin errors++; $display("FAIL w8_wrap got %h want ff", last); end
    checks++; if (d_wc !== 32'd254 && d_wc !== 32'd255) begin
      errors++; $display("FAIL w8_wc got %0d want 254..255", d_wc); end
  endtask

  initial begin
    a_rst = 1'b0; a_en = 1'b0; a_sv = 1'b0; a_seed = '0; a_rdy = 1'b0;
    b_rst = 1'b0; b_en = 1'b0; b_sv = 1'b0; b_seed = '0; b_rdy = 1'b0;
    c_rst = 1'b0; c_en = 1'b0; c_sv = 1'b0; c_seed = '0; c_rdy = 1'b0;
    d_rst = 1'b0; d_en = 1'b0; d_sv = 1'b0; d_seed = '0; d_rdy = 1'b0;
    tick(); tick();
    test_reset();
    test_default_seq();
    test_zero_seed_hold();
    test_seed_handshake();
    test_reset_mid_hold();
    test_seed_over_enable();
    test_steps4_hold();
    test_enable_toggle();
    test_width8_period();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
